// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC register, 2-entry {instruction, pc} fetch FIFO, halt detect.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky fetch_fault for misaligned redirects.
module fetch_queue_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] read_addr,
   input  logic [31:0] instruction,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   output logic        halted
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic        fetch_fault
`endif
);

   typedef enum logic {RUN, HALT} state_t;

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [1:0]  count, count_next;
   logic [31:0] ins0, ins1, epc0, epc1;
   logic [31:0] ins0_next, ins1_next, epc0_next, epc1_next;
   logic [1:0]  level;
   logic [31:0] target;
   logic        pop, push;

   always_comb begin
      target     = redirect_addr;
`ifdef FETCH_ALIGN_CHECK_EN
      target[1:0] = 2'b00;
`endif
      pop        = instr_valid && instr_ready;
      push       = (state == RUN) && !redirect && (count != 2'd2 || pop);
      level      = count - 2'(pop);
      state_next = state;
      pc_next    = pc;
      count_next = count;
      ins0_next  = ins0;
      ins1_next  = ins1;
      epc0_next  = epc0;
      epc1_next  = epc1;
      if (redirect) begin
         // flush wins over any pop, push or halt detection this edge
         count_next = 2'd0;
         pc_next    = target;
         state_next = RUN;
      end else begin
         if (pop) begin
            ins0_next = ins1;
            epc0_next = epc1;
         end
         if (push) begin
            if (level == 2'd0) begin
               ins0_next = instruction;
               epc0_next = pc;
            end else begin
               ins1_next = instruction;
               epc1_next = pc;
            end
            if (instruction == HALT_WORD) state_next = HALT;
            else pc_next = pc + 32'd4;
         end
         count_next = count - 2'(pop) + 2'(push);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= RUN;
         pc    <= RESET_PC;
         count <= 2'd0;
         ins0  <= 32'd0;
         ins1  <= 32'd0;
         epc0  <= 32'd0;
         epc1  <= 32'd0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         count <= count_next;
         ins0  <= ins0_next;
         ins1  <= ins1_next;
         epc0  <= epc0_next;
         epc1  <= epc1_next;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) fetch_fault <= 1'b0;
      else if (redirect && redirect_addr[1:0] != 2'b00) fetch_fault <= 1'b1;
   end
`endif

   assign read_addr   = pc;
   assign instr_valid = (count != 2'd0);
   assign instr_out   = instr_valid ? ins0 : 32'd0;
   assign pc_out      = instr_valid ? epc0 : 32'd0;
   assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: per-cycle vector table plus an entry scoreboard.
// Address-tagged memory model; the word at 0x0C can be made HALT_WORD.
module tb_fetch_queue_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] read_addr;
   logic [31:0] instruction;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_addr = 32'd0;
   logic        halted;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fetch_fault;
`endif

   logic        halt_en = 1'b0;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] sb[$];

   fetch_queue_unit dut (
      .clock        (clock),
      .reset        (reset),
      .read_addr    (read_addr),
      .instruction  (instruction),
      .instr_out    (instr_out),
      .pc_out       (pc_out),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .redirect     (redirect),
      .redirect_addr(redirect_addr),
      .halted       (halted)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .fetch_fault  (fetch_fault)
`endif
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (halt_en && a == 32'h0000_000C) return 32'hFFFF_FFFF;
      return a ^ 32'h5A00_0000;
   endfunction

   assign instruction = mem(read_addr);

   typedef struct {
      bit          rst;
      bit          hen;
      bit          rdy;
      bit          rd;
      logic [31:0] ra;
      bit          push;
      logic [31:0] ppc;
      bit          ev;
      logic [31:0] epc;
      logic [31:0] era;
      bit          eh;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(bit rst, bit hen, bit rdy, bit rd,
                              logic [31:0] ra, bit push, logic [31:0] ppc,
                              bit ev, logic [31:0] epc, logic [31:0] era,
                              bit eh);
      vec_t r;
      r.rst = rst; r.hen = hen; r.rdy = rdy; r.rd = rd; r.ra = ra;
      r.push = push; r.ppc = ppc; r.ev = ev; r.epc = epc; r.era = era;
      r.eh = eh;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic reset_checks();
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_pc_out", pc_out, 32'd0);
      chk("rst_instr_out", instr_out, 32'd0);
      chk("rst_read_addr", read_addr, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("rst_fault", 32'(fetch_fault), 32'd0);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset + streaming
      vecs.push_back(v(1,0,1,0,0, 1,0, 0,0,0,0));
      vecs.push_back(v(0,0,1,0,0, 1,4, 1,0,4,0));
      vecs.push_back(v(0,0,1,0,0, 1,8, 1,4,8,0));
      vecs.push_back(v(0,0,1,0,0, 1,12, 1,8,12,0));
      vecs.push_back(v(0,0,1,0,0, 1,16, 1,12,16,0));
      // stall with ready low for 5 cycles
      vecs.push_back(v(1,0,0,0,0, 1,0, 0,0,0,0));
      vecs.push_back(v(0,0,0,0,0, 1,4, 1,0,4,0));
      vecs.push_back(v(0,0,0,0,0, 0,0, 1,0,8,0));
      vecs.push_back(v(0,0,0,0,0, 0,0, 1,0,8,0));
      vecs.push_back(v(0,0,0,0,0, 0,0, 1,0,8,0));
      vecs.push_back(v(0,0,1,0,0, 1,8, 1,0,8,0));
      vecs.push_back(v(0,0,1,0,0, 1,12, 1,4,12,0));
      vecs.push_back(v(0,0,1,0,0, 1,16, 1,8,16,0));
      // redirect with two entries queued, pop attempted same edge
      vecs.push_back(v(1,0,0,0,0, 1,0, 0,0,0,0));
      vecs.push_back(v(0,0,0,0,0, 1,4, 1,0,4,0));
      vecs.push_back(v(0,0,1,1,32'h100, 0,0, 1,0,8,0));
      vecs.push_back(v(0,0,1,0,0, 1,32'h100, 0,0,32'h100,0));
      vecs.push_back(v(0,0,1,0,0, 1,32'h104, 1,32'h100,32'h104,0));
      vecs.push_back(v(0,0,1,0,0, 1,32'h108, 1,32'h104,32'h108,0));
      // halt word at 0x0C, drain, redirect to 0 resumes
      vecs.push_back(v(1,1,1,0,0, 1,0, 0,0,0,0));
      vecs.push_back(v(0,1,1,0,0, 1,4, 1,0,4,0));
      vecs.push_back(v(0,1,1,0,0, 1,8, 1,4,8,0));
      vecs.push_back(v(0,1,1,0,0, 1,12, 1,8,12,0));
      vecs.push_back(v(0,1,1,0,0, 0,0, 1,12,12,1));
      vecs.push_back(v(0,1,1,0,0, 0,0, 0,0,12,1));
      vecs.push_back(v(0,1,1,0,0, 0,0, 0,0,12,1));
      vecs.push_back(v(0,1,1,1,0, 0,0, 0,0,12,1));
      vecs.push_back(v(0,1,1,0,0, 1,0, 0,0,0,0));
      vecs.push_back(v(0,1,1,0,0, 1,4, 1,0,4,0));
      // PC wrap
      vecs.push_back(v(1,0,1,1,32'hFFFF_FFFC, 0,0, 0,0,0,0));
      vecs.push_back(v(0,0,1,0,0, 1,32'hFFFF_FFFC, 0,0,32'hFFFF_FFFC,0));
      vecs.push_back(v(0,0,1,0,0, 1,0, 1,32'hFFFF_FFFC,0,0));
      vecs.push_back(v(0,0,1,0,0, 1,4, 1,0,4,0));

      foreach (vecs[i]) begin
         @(negedge clock);
         if (vecs[i].rst) begin
            reset = 1'b1;
            instr_ready = 1'b0;
            redirect = 1'b0;
            sb.delete();
            #1;
            reset_checks();
            @(negedge clock);
            reset = 1'b0;
         end
         halt_en       = vecs[i].hen;
         instr_ready   = vecs[i].rdy;
         redirect      = vecs[i].rd;
         redirect_addr = vecs[i].ra;
         #1;
         chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].ev));
         chk($sformatf("v%0d_pc_out", i), pc_out, vecs[i].epc);
         chk($sformatf("v%0d_read_addr", i), read_addr, vecs[i].era);
         chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].eh));
         if (instr_valid && instr_ready && !redirect) begin
            if (sb.size() == 0) begin
               chk($sformatf("v%0d_sb_empty", i), pc_out, 32'hDEAD_BEEF);
            end else begin
               logic [31:0] e;
               e = sb.pop_front();
               chk($sformatf("v%0d_sb_pc", i), pc_out, e);
               chk($sformatf("v%0d_sb_instr", i), instr_out, mem(e));
            end
         end
         if (redirect) sb.delete();
         if (vecs[i].push) sb.push_back(vecs[i].ppc);
      end

      // asynchronous reset mid-operation
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("async_valid", 32'(instr_valid), 32'd0);
      chk("async_read_addr", read_addr, 32'd0);
      chk("async_instr_out", instr_out, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      redirect = 1'b0;
      instr_ready = 1'b1;
      #1;
      chk("post_rst_valid", 32'(instr_valid), 32'd0);
      @(negedge clock);
      #1;
      chk("post_rst_first_valid", 32'(instr_valid), 32'd1);
      chk("post_rst_first_pc", pc_out, 32'd0);

`ifdef FETCH_ALIGN_CHECK_EN
      @(negedge clock);
      reset = 1'b1;
      #1;
      reset_checks();
      @(negedge clock);
      reset = 1'b0;
      redirect = 1'b1;
      redirect_addr = 32'h102;
      #1;
      chk("fault_before", 32'(fetch_fault), 32'd0);
      @(negedge clock);
      redirect = 1'b0;
      #1;
      chk("fault_set", 32'(fetch_fault), 32'd1);
      chk("fault_read_addr", read_addr, 32'h100);
      @(negedge clock);
      #1;
      chk("fault_pc_out", pc_out, 32'h100);
      repeat (3) @(negedge clock);
      #1;
      chk("fault_sticky", 32'(fetch_fault), 32'd1);
      reset = 1'b1;
      #1;
      chk("fault_cleared", 32'(fetch_fault), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
